// File: rtl/aes_pkg.sv
// Shared types and widths for the AES-CTR plaintext path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package aes_pkg;

  localparam int BLOCK_W = 128;
  localparam int IDX_W   = 32;

  // One buffered plaintext block together with its counter word.
  typedef struct packed {
    logic [BLOCK_W-1:0] block;
    logic [IDX_W-1:0]   idx;
  } ptxt_entry_t;

endpackage

// File: rtl/ptxt_fifo_mem.sv
// Entry storage for ptxt_fifo: DEPTH x W flops, one write port, one async read port.
// Latency: write lands on the clock edge, read is combinational from rd_addr.
// Backpressure: none here; the parent only asserts wr_en for accepted pushes.
module ptxt_fifo_mem #(
  parameter int DEPTH = 4,
  parameter int W     = aes_pkg::BLOCK_W + aes_pkg::IDX_W
) (
  input  logic                     HCLK,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [W-1:0]             wr_word,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [W-1:0]             rd_word
);

  // Contents are only meaningful behind the parent's pointers, so no reset.
  logic [W-1:0] mem [DEPTH];

  // Write the addressed entry on an accepted push.
  always_ff @(posedge HCLK) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_word;
    end
  end

  assign rd_word = mem[rd_addr];

endmodule

// File: rtl/ptxt_fifo.sv
// Plaintext FIFO between the AHB write slave and the AES-CTR core; tags each block with a block index.
// Latency: 1 cycle push-to-rd_valid, first-word-fall-through head (rd_data/rd_idx combinational).
// Backpressure: fifo_full stalls the writer (pushes while full are dropped and flagged); rd_valid/rd_ready on the read side.
// Build option: define PTXT_FIFO_OVF_CNT_EN to get a saturating dropped-push counter on ovf_count.
module ptxt_fifo
  import aes_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int IDX_W = aes_pkg::IDX_W
) (
  input  logic                     HCLK,
  input  logic                     HRESET,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [BLOCK_W-1:0]       wr_data,
  output logic                     fifo_full,
  output logic                     fifo_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     rd_valid,
  output logic [BLOCK_W-1:0]       rd_data,
  output logic [IDX_W-1:0]         rd_idx,
  input  logic                     rd_ready,
  output logic                     overflow,
  output logic [7:0]               ovf_count
);

  localparam int            PW       = $clog2(DEPTH);
  localparam int            EW       = BLOCK_W + IDX_W;
  localparam logic [PW:0]   FULL_CNT = (PW + 1)'(DEPTH);

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count_q;
  logic [IDX_W-1:0] next_idx;
  logic             ovf_q;
  logic             push;
  logic             pop;
  logic             drop;
  logic             mem_we;
  logic [EW-1:0]    rd_word;

  // Occupancy flags come straight off the count register, so full is a registered condition.
  assign fifo_full  = (count_q == FULL_CNT);
  assign fifo_empty = (count_q == '0);
  assign rd_valid   = !fifo_empty;
  assign count      = count_q;
  assign overflow   = ovf_q;

  // A push against a full buffer is dropped even if the head pops in the same cycle.
  assign push   = wr_en && !fifo_full;
  assign drop   = wr_en && fifo_full;
  assign pop    = rd_valid && rd_ready;
  assign mem_we = push && !flush && !HRESET;

  ptxt_fifo_mem #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_mem (
    .HCLK    (HCLK),
    .wr_en   (mem_we),
    .wr_addr (wr_ptr),
    .wr_word ({wr_data, next_idx}),
    .rd_addr (rd_ptr),
    .rd_word (rd_word)
  );

  assign rd_data = rd_word[EW-1:IDX_W];
  assign rd_idx  = rd_word[IDX_W-1:0];

  // Pointer, occupancy, index and sticky-overflow state; reset beats flush beats push/pop.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      next_idx <= '0;
      ovf_q    <= 1'b0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      next_idx <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + 1'b1;
        next_idx <= next_idx + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
      if (drop) begin
        ovf_q <= 1'b1;
      end
    end
  end

`ifdef PTXT_FIFO_OVF_CNT_EN
  logic [7:0] ovf_cnt_q;

  // Count dropped pushes, holding at all-ones rather than wrapping.
  always_ff @(posedge HCLK) begin
    if (HRESET || flush) begin
      ovf_cnt_q <= 8'h00;
    end else if (drop && (ovf_cnt_q != 8'hFF)) begin
      ovf_cnt_q <= ovf_cnt_q + 8'h01;
    end
  end

  assign ovf_count = ovf_cnt_q;
`else
  assign ovf_count = 8'h00;
`endif

endmodule
